dmem_arbiter: RTL and testbench

Two-port arbiter that shares the single-ported data memory between the pipeline's MEM stage (port 0) and a debug/DMA loader (port 1). It accepts at most one access per cycle, issues it to the memory and returns synchronous read data one cycle later on the port that issued the read. It also drives the stall the pipeline uses while the CPU is losing arbitration. Arbitration is round-robin, plus a bounded lock that lets port 1 hold the memory for short bursts.

---
 rtl/dmem_arbiter_if.sv | 52 +++++
 rtl/dmem_arbiter.sv | 95 +++++++++
 tb/tb_dmem_arbiter.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Bundle of the two requester ports, the pipeline stall and the data-memory
// side of the arbiter. The arbiter connects through the slave modport.
interface dmem_arbiter_if #(
    parameter int MAW = 10
);
    logic            p0_valid;
    logic            p0_we;
    logic [31:0]     p0_addr;
    logic [31:0]     p0_wdata;
    logic [3:0]      p0_wmask;
    logic            p0_ready;
    logic            p0_rvalid;
    logic [31:0]     p0_rdata;

    logic            p1_valid;
    logic            p1_we;
    logic [31:0]     p1_addr;
    logic [31:0]     p1_wdata;
    logic [3:0]      p1_wmask;
    logic            p1_lock;
    logic            p1_ready;
    logic            p1_rvalid;
    logic [31:0]     p1_rdata;

    logic            cpu_stall;

    logic            mem_en;
    logic [3:0]      mem_we;
    logic [MAW-1:0]  mem_addr;
    logic [31:0]     mem_wdata;
    logic [31:0]     mem_rdata;

    modport slave (
        input  p0_valid, p0_we, p0_addr, p0_wdata, p0_wmask,
        input  p1_valid, p1_we, p1_addr, p1_wdata, p1_wmask, p1_lock,
        input  mem_rdata,
        output p0_ready, p0_rvalid, p0_rdata,
        output p1_ready, p1_rvalid, p1_rdata,
        output cpu_stall,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output p0_valid, p0_we, p0_addr, p0_wdata, p0_wmask,
        output p1_valid, p1_we, p1_addr, p1_wdata, p1_wmask, p1_lock,
        output mem_rdata,
        input  p0_ready, p0_rvalid, p0_rdata,
        input  p1_ready, p1_rvalid, p1_rdata,
        input  cpu_stall,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single-ported data memory between the MEM
// stage (port 0) and the debug/DMA loader (port 1), with a bounded port-1 lock.
module dmem_arbiter #(
    parameter int MAW      = 10,
    parameter int LOCK_MAX = 8
) (
    input  logic           clk,
    input  logic           reset,
    dmem_arbiter_if.slave  bus
);
    localparam int LW = $clog2(LOCK_MAX + 1);

    logic          last;
    logic [LW-1:0] lock_cnt;
    logic          rd_pend;
    logic          rd_port;

    logic          gnt0;
    logic          gnt1;
    logic          locked;
    logic          rd_acc;

    // Grants are forced off while reset is held so every output reads zero.
    always_comb begin
        gnt0   = 1'b0;
        gnt1   = 1'b0;
        locked = last & bus.p1_lock & (lock_cnt < LW'(LOCK_MAX));
        if (!reset) begin
            if (bus.p0_valid && bus.p1_valid) begin
                gnt1 = locked | ~last;
                gnt0 = ~(locked | ~last);
            end else if (bus.p0_valid) begin
                gnt0 = 1'b1;
            end else if (bus.p1_valid) begin
                gnt1 = 1'b1;
            end
        end
    end

    always_comb begin
        bus.mem_en    = gnt0 | gnt1;
        bus.mem_we    = 4'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = 32'b0;
        if (gnt1) begin
            bus.mem_we    = bus.p1_we ? bus.p1_wmask : 4'b0;
            bus.mem_addr  = bus.p1_addr[MAW+1:2];
            bus.mem_wdata = bus.p1_wdata;
        end else if (gnt0) begin
            bus.mem_we    = bus.p0_we ? bus.p0_wmask : 4'b0;
            bus.mem_addr  = bus.p0_addr[MAW+1:2];
            bus.mem_wdata = bus.p0_wdata;
        end
    end

    assign rd_acc = (gnt0 & ~bus.p0_we) | (gnt1 & ~bus.p1_we);

    assign bus.p0_ready  = gnt0;
    assign bus.p1_ready  = gnt1;
    assign bus.cpu_stall = ~reset & bus.p0_valid & ~gnt0;

    assign bus.p0_rvalid = rd_pend & ~rd_port;
    assign bus.p1_rvalid = rd_pend & rd_port;
    assign bus.p0_rdata  = bus.p0_rvalid ? bus.mem_rdata : 32'b0;
    assign bus.p1_rdata  = bus.p1_rvalid ? bus.mem_rdata : 32'b0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last     <= 1'b1;
            lock_cnt <= '0;
            rd_pend  <= 1'b0;
            rd_port  <= 1'b0;
        end else begin
            if (gnt0 | gnt1) begin
                last <= gnt1;
            end
            // Counts port-1 grants that kept a waiting port 0 out.
            if (gnt1 & bus.p0_valid) begin
                if (lock_cnt != LW'(LOCK_MAX)) begin
                    lock_cnt <= lock_cnt + LW'(1);
                end
            end else begin
                lock_cnt <= '0;
            end
            rd_pend <= rd_acc;
            if (rd_acc) begin
                rd_port <= gnt1;
            end
        end
    end

    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.p0_addr[1:0], bus.p0_addr[31:MAW+2],
                                bus.p1_addr[1:0], bus.p1_addr[31:MAW+2]};
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed and randomized bench for dmem_arbiter against a request-level
// reference model with a shadow copy of the data memory.
module tb_dmem_arbiter;
    localparam int MAW      = 10;
    localparam int LOCK_MAX = 8;

    logic clk;
    logic reset;

    dmem_arbiter_if #(.MAW(MAW)) bus ();

    dmem_arbiter #(.MAW(MAW), .LOCK_MAX(LOCK_MAX)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory behind the arbiter, plus a preload path used while reset is held.
    logic [31:0] mem [0:31];
    logic        pre_we;
    logic [4:0]  pre_idx;
    logic [31:0] pre_val;

    always @(posedge clk) begin
        if (pre_we) begin
            mem[pre_idx] <= pre_val;
        end else if (bus.mem_en) begin
            if (bus.mem_we != 4'b0) begin
                for (int b = 0; b < 4; b++) begin
                    if (bus.mem_we[b]) mem[bus.mem_addr[4:0]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
                end
            end else begin
                bus.mem_rdata <= mem[bus.mem_addr[4:0]];
            end
        end
    end

    int n_cmp;
    int n_err;

    int          m_last;
    int          m_streak;
    bit          m_pend;
    int          m_pport;
    logic [31:0] m_pdata;
    logic [31:0] shadow [0:31];
    int          last_w;

    logic        o_r0, o_r1, o_stall, o_rv0, o_rv1;
    logic [3:0]  o_we;
    logic [MAW-1:0] o_addr;
    logic [31:0] o_rd0;

    function automatic logic [31:0] preval(input int i);
        if (i == 5) return 32'hDEADBEEF;
        return (32'h01010101 * (i + 1)) ^ 32'hC0DE0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_last   = 1;
        m_streak = 0;
        m_pend   = 1'b0;
        m_pport  = 0;
    endtask

    // One cycle: called just after a falling edge with inputs already driven.
    task automatic step();
        int          w;
        logic        we;
        logic [31:0] addr, wdata;
        logic [3:0]  wmask;
        int          wi;
        #1;
        w = -1;
        if (!reset) begin
            if (bus.p0_valid && bus.p1_valid)
                w = (m_last == 1 && bus.p1_lock && m_streak < LOCK_MAX) ? 1 : 1 - m_last;
            else if (bus.p0_valid) w = 0;
            else if (bus.p1_valid) w = 1;
        end
        we    = (w == 1) ? bus.p1_we    : bus.p0_we;
        addr  = (w == 1) ? bus.p1_addr  : bus.p0_addr;
        wdata = (w == 1) ? bus.p1_wdata : bus.p0_wdata;
        wmask = (w == 1) ? bus.p1_wmask : bus.p0_wmask;
        wi    = int'(addr[6:2]);

        o_r0 = bus.p0_ready; o_r1 = bus.p1_ready; o_stall = bus.cpu_stall;
        o_rv0 = bus.p0_rvalid; o_rv1 = bus.p1_rvalid; o_we = bus.mem_we;
        o_addr = bus.mem_addr; o_rd0 = bus.p0_rdata;

        chk("p0_ready", 32'(bus.p0_ready), 32'(w == 0));
        chk("p1_ready", 32'(bus.p1_ready), 32'(w == 1));
        chk("cpu_stall", 32'(bus.cpu_stall), 32'(!reset && bus.p0_valid && w != 0));
        chk("mem_en", 32'(bus.mem_en), 32'(w >= 0));
        if (w >= 0) begin
            chk("mem_we", 32'(bus.mem_we), 32'(we ? wmask : 4'b0));
            chk("mem_addr", 32'(bus.mem_addr), 32'(addr[MAW+1:2]));
            chk("mem_wdata", bus.mem_wdata, wdata);
        end else begin
            chk("mem_we_idle", 32'(bus.mem_we), 32'd0);
        end
        chk("p0_rvalid", 32'(bus.p0_rvalid), 32'(!reset && m_pend && m_pport == 0));
        chk("p1_rvalid", 32'(bus.p1_rvalid), 32'(!reset && m_pend && m_pport == 1));
        chk("p0_rdata", bus.p0_rdata, (!reset && m_pend && m_pport == 0) ? m_pdata : 32'd0);
        chk("p1_rdata", bus.p1_rdata, (!reset && m_pend && m_pport == 1) ? m_pdata : 32'd0);

        if (reset) begin
            model_reset();
        end else begin
            m_pend   = 1'b0;
            m_streak = (w == 1 && bus.p0_valid) ?
                       ((m_streak + 1 > LOCK_MAX) ? LOCK_MAX : m_streak + 1) : 0;
            if (w >= 0) begin
                m_last = w;
                if (we) begin
                    for (int b = 0; b < 4; b++)
                        if (wmask[b]) shadow[wi][8*b +: 8] = wdata[8*b +: 8];
                end else begin
                    m_pend  = 1'b1;
                    m_pport = w;
                    m_pdata = shadow[wi];
                end
            end
        end
        last_w = w;
        @(negedge clk);
    endtask

    initial begin
        n_cmp = 0; n_err = 0; last_w = -1;
        model_reset();
        m_pdata = 32'd0;
        reset = 1'b1;
        pre_we = 1'b0; pre_idx = 5'd0; pre_val = 32'd0;
        bus.mem_rdata = 32'd0;
        bus.p0_valid = 1'b1; bus.p0_we = 1'b0; bus.p0_addr = 32'h14;
        bus.p0_wdata = 32'd0; bus.p0_wmask = 4'hF;
        bus.p1_valid = 1'b1; bus.p1_we = 1'b1; bus.p1_addr = 32'h8;
        bus.p1_wdata = 32'hFFFFFFFF; bus.p1_wmask = 4'hF; bus.p1_lock = 1'b1;
        @(negedge clk);

        // Reset held with both ports requesting; memory preloaded meanwhile.
        pre_we = 1'b1;
        for (int i = 0; i < 32; i++) begin
            pre_idx = 5'(i); pre_val = preval(i); shadow[i] = preval(i);
            step();
        end
        pre_we = 1'b0;

        // First tie after reset goes to port 0.
        reset = 1'b0;
        bus.p1_we = 1'b0; bus.p1_lock = 1'b0;
        step();
        chk("tie_p0_ready", 32'(o_r0), 32'd1);
        chk("tie_p1_ready", 32'(o_r1), 32'd0);

        // Single-port read of word 5.
        bus.p1_valid = 1'b0;
        step();
        chk("sr_mem_addr", 32'(o_addr), 32'd5);
        bus.p0_valid = 1'b0;
        step();
        chk("sr_p0_rvalid", 32'(o_rv0), 32'd1);
        chk("sr_p0_rdata", o_rd0, 32'hDEADBEEF);
        chk("sr_p1_rvalid", 32'(o_rv1), 32'd0);

        // Continuous reads on both ports; port 0 was granted last.
        bus.p0_valid = 1'b1; bus.p0_we = 1'b0; bus.p0_addr = 32'h4;
        bus.p1_valid = 1'b1; bus.p1_we = 1'b0; bus.p1_addr = 32'h1C;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("rr_p1_ready", 32'(o_r1), 32'(k % 2 == 0));
            chk("rr_cpu_stall", 32'(o_stall), 32'(k % 2 == 0));
        end

        // Locked port-1 write burst while port 0 waits.
        bus.p1_we = 1'b1; bus.p1_addr = 32'h50; bus.p1_wdata = 32'h5A5A0F0F;
        bus.p1_wmask = 4'hF; bus.p1_lock = 1'b1;
        bus.p0_addr = 32'h0;
        for (int k = 0; k < LOCK_MAX + 2; k++) begin
            step();
            chk("lock_p1_ready", 32'(o_r1), 32'(k != LOCK_MAX));
        end

        // Byte write to word 2, then read it back.
        bus.p0_valid = 1'b0; bus.p1_lock = 1'b0;
        bus.p1_valid = 1'b1; bus.p1_we = 1'b1; bus.p1_addr = 32'h8;
        bus.p1_wdata = 32'h11223344; bus.p1_wmask = 4'b0100;
        step();
        chk("bw_mem_we", 32'(o_we), 32'h4);
        bus.p1_valid = 1'b0;
        bus.p0_valid = 1'b1; bus.p0_we = 1'b0; bus.p0_addr = 32'h8;
        step();
        bus.p0_valid = 1'b0;
        step();
        chk("bw_readback", o_rd0, (preval(2) & 32'hFF00FFFF) | 32'h00220000);

        // Reset arrives in the cycle the accepted read would return.
        bus.p0_valid = 1'b1; bus.p0_addr = 32'h14;
        #1;
        chk("rst_rd_ready", 32'(bus.p0_ready), 32'd1);
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("rst_rd_rvalid", 32'(bus.p0_rvalid), 32'd0);
        chk("rst_rd_rdata", bus.p0_rdata, 32'd0);
        model_reset();
        @(negedge clk);
        bus.p0_valid = 1'b0;
        step();
        step();
        reset = 1'b0;
        step();
        chk("rst_after_rvalid", 32'(o_rv0), 32'd0);

        // Randomized traffic; losers hold their requests until granted.
        bus.p0_valid = 1'b0; bus.p1_valid = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if (!bus.p0_valid || last_w == 0) begin
                bus.p0_valid = ($urandom % 4) != 0;
                bus.p0_we    = 1'($urandom % 2);
                bus.p0_addr  = {25'd0, 5'($urandom % 32), 2'($urandom % 4)};
                bus.p0_wdata = $urandom;
                bus.p0_wmask = 4'($urandom);
            end
            if (!bus.p1_valid || last_w == 1) begin
                bus.p1_valid = ($urandom % 4) != 0;
                bus.p1_we    = 1'($urandom % 2);
                bus.p1_addr  = {25'd0, 5'($urandom % 32), 2'($urandom % 4)};
                bus.p1_wdata = $urandom;
                bus.p1_wmask = 4'($urandom);
            end
            bus.p1_lock = ($urandom % 3) != 0;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
